secded_codec: RTL and testbench

Parametrised SECDED (single-error-correct, double-error-detect) Hamming codec for the link test path. It holds an encoder channel (TX side, data in, codeword out) and a two-stage pipelined decoder channel (RX side, codeword in, corrected data out). Both channels are independent and use valid/ready handshakes. Saturating counters record corrected and uncorrectable words so the noisy-channel model can be characterised over long runs.

---
 rtl/secded_codec_if.sv | 54 +++++
 rtl/secded_codec.sv | 186 ++++++++++++++++++
 tb/tb_secded_codec.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/secded_codec_if.sv
// Handshake and status bundle for the SECDED codec: encoder channel, decoder channel and error counters.
// Widths follow the same P/CW derivation as the codec itself.
interface secded_codec_if #(
  parameter int DATA_W = 7,
  parameter int CNT_W  = 16
);
  function automatic int calcP(input int dw);
    int p;
    p = 0;
    for (int k = 7; k >= 1; k--)
      if ((1 << k) >= dw + k + 1) p = k;
    return p;
  endfunction

  localparam int P  = calcP(DATA_W);
  localparam int CW = DATA_W + P + 1;

  logic              enc_in_valid;
  logic              enc_in_ready;
  logic [DATA_W-1:0] enc_data;
  logic              enc_out_valid;
  logic              enc_out_ready;
  logic [CW-1:0]     enc_code;

  logic              dec_in_valid;
  logic              dec_in_ready;
  logic [CW-1:0]     dec_code;
  logic              dec_out_valid;
  logic              dec_out_ready;
  logic [DATA_W-1:0] dec_data;
  logic              dec_corrected;
  logic              dec_uncorrectable;
  logic [P-1:0]      dec_syndrome;

  logic              cnt_clear;
  logic [CNT_W-1:0]  corr_count;
  logic [CNT_W-1:0]  uncorr_count;

  modport slave (
    input  enc_in_valid, enc_data, enc_out_ready,
    input  dec_in_valid, dec_code, dec_out_ready, cnt_clear,
    output enc_in_ready, enc_out_valid, enc_code,
    output dec_in_ready, dec_out_valid, dec_data, dec_corrected,
    output dec_uncorrectable, dec_syndrome, corr_count, uncorr_count
  );

  modport master (
    output enc_in_valid, enc_data, enc_out_ready,
    output dec_in_valid, dec_code, dec_out_ready, cnt_clear,
    input  enc_in_ready, enc_out_valid, enc_code,
    input  dec_in_ready, dec_out_valid, dec_data, dec_corrected,
    input  dec_uncorrectable, dec_syndrome, corr_count, uncorr_count
  );
endinterface

// File: rtl/secded_codec.sv
// SECDED Hamming codec: one-register encoder and two-stage pipelined decoder with independent
// valid/ready channels, plus saturating corrected/uncorrectable event counters.
module secded_codec #(
  parameter int DATA_W = 7,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  secded_codec_if.slave bus
);
  function automatic int calcP(input int dw);
    int p;
    p = 0;
    for (int k = 7; k >= 1; k--)
      if ((1 << k) >= dw + k + 1) p = k;
    return p;
  endfunction

  localparam int          P  = calcP(DATA_W);
  localparam int          CW = DATA_W + P + 1;
  localparam int unsigned N  = DATA_W + P;

  function automatic logic [P-1:0] syndrome(input logic [CW-1:0] c);
    logic [P-1:0] s;
    s = '0;
    for (int unsigned i = 1; i <= N; i++)
      if (c[i]) s ^= i[P-1:0];
    return s;
  endfunction

  // Parity positions are zero while data is placed, so the syndrome of that partial word
  // is exactly the parity vector that makes the full syndrome zero.
  function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW-1:0] c;
    logic [P-1:0]  s;
    int unsigned   j;
    c = '0;
    j = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    s = syndrome(c);
    for (int unsigned k = 0; k < P; k++)
      c[1 << k] = s[k];
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] c);
    logic [DATA_W-1:0] d;
    int unsigned       j;
    d = '0;
    j = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  // Encoder channel
  logic          encOutValid;
  logic [CW-1:0] encCode;
  logic          encInReady;

  assign encInReady = !encOutValid || bus.enc_out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      encOutValid <= 1'b0;
      encCode     <= '0;
    end else if (encInReady) begin
      encOutValid <= bus.enc_in_valid;
      if (bus.enc_in_valid) encCode <= encode(bus.enc_data);
    end
  end

  assign bus.enc_in_ready  = encInReady;
  assign bus.enc_out_valid = encOutValid;
  assign bus.enc_code      = encCode;

  // Decoder stage 1: captured codeword with its syndrome and overall parity
  logic          s1Valid;
  logic [CW-1:0] s1Code;
  logic [P-1:0]  s1Syn;
  logic          s1Op;

  // Decoder stage 2 / output registers
  logic              decOutValid;
  logic [DATA_W-1:0] decData;
  logic              decCorrected;
  logic              decUncorrectable;
  logic [P-1:0]      decSyndrome;

  logic s2Free;
  logic decInReady;

  assign s2Free     = !decOutValid || bus.dec_out_ready;
  assign decInReady = !s1Valid || s2Free;

  logic [CW-1:0] fixedCode;
  logic          nextCorr;
  logic          nextUnc;

  always_comb begin
    fixedCode = s1Code;
    nextCorr  = 1'b0;
    nextUnc   = 1'b0;
    if (s1Op) begin
      if (s1Syn == '0) begin
        nextCorr = 1'b1;
      end else if (32'(s1Syn) <= N) begin
        fixedCode[s1Syn] = ~s1Code[s1Syn];
        nextCorr         = 1'b1;
      end else begin
        nextUnc = 1'b1;
      end
    end else if (s1Syn != '0) begin
      nextUnc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1Valid          <= 1'b0;
      s1Code           <= '0;
      s1Syn            <= '0;
      s1Op             <= 1'b0;
      decOutValid      <= 1'b0;
      decData          <= '0;
      decCorrected     <= 1'b0;
      decUncorrectable <= 1'b0;
      decSyndrome      <= '0;
    end else begin
      if (s2Free) begin
        decOutValid <= s1Valid;
        if (s1Valid) begin
          decData          <= extract(fixedCode);
          decCorrected     <= nextCorr;
          decUncorrectable <= nextUnc;
          decSyndrome      <= s1Syn;
        end
      end
      if (decInReady) begin
        s1Valid <= bus.dec_in_valid;
        if (bus.dec_in_valid) begin
          s1Code <= bus.dec_code;
          s1Syn  <= syndrome(bus.dec_code);
          s1Op   <= ^bus.dec_code;
        end
      end
    end
  end

  assign bus.dec_in_ready      = decInReady;
  assign bus.dec_out_valid     = decOutValid;
  assign bus.dec_data          = decData;
  assign bus.dec_corrected     = decCorrected;
  assign bus.dec_uncorrectable = decUncorrectable;
  assign bus.dec_syndrome      = decSyndrome;

  // Event counters; a clear in the same cycle as an event wins
  logic [CNT_W-1:0] corrCount;
  logic [CNT_W-1:0] uncorrCount;
  logic             decFire;

  assign decFire = decOutValid && bus.dec_out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.cnt_clear) begin
      corrCount   <= '0;
      uncorrCount <= '0;
    end else if (decFire) begin
      if (decCorrected && corrCount != '1)       corrCount   <= corrCount + 1'b1;
      if (decUncorrectable && uncorrCount != '1) uncorrCount <= uncorrCount + 1'b1;
    end
  end

  assign bus.corr_count   = corrCount;
  assign bus.uncorr_count = uncorrCount;
endmodule

// File: tb/tb_secded_codec.sv
// Directed bench for secded_codec at DATA_W=7, CNT_W=2: encode/decode vectors, stalls,
// counter saturation and clear, randomised-backpressure loopback stream and mid-stream reset.
module tb_secded_codec;
  localparam int DW   = 7;
  localparam int CNTW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int expCorr   = 0;
  int expUncorr = 0;

  secded_codec_if #(.DATA_W(DW), .CNT_W(CNTW)) bus ();

  secded_codec #(.DATA_W(DW), .CNT_W(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.enc_in_valid  = 1'b0;
    bus.enc_data      = '0;
    bus.enc_out_ready = 1'b1;
    bus.dec_in_valid  = 1'b0;
    bus.dec_code      = '0;
    bus.dec_out_ready = 1'b1;
    bus.cnt_clear     = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({bus.enc_out_valid, bus.enc_code} !== 13'h0) begin
      failures++;
      $display("FAIL reset_enc got=%0b/%h exp=0/000", bus.enc_out_valid, bus.enc_code);
    end
    checks++;
    if ({bus.dec_out_valid, bus.dec_data, bus.dec_corrected, bus.dec_uncorrectable, bus.dec_syndrome} !== 14'h0) begin
      failures++;
      $display("FAIL reset_dec got v=%0b d=%h c=%0b u=%0b s=%0d exp all 0", bus.dec_out_valid, bus.dec_data,
               bus.dec_corrected, bus.dec_uncorrectable, bus.dec_syndrome);
    end
    checks++;
    if ({bus.corr_count, bus.uncorr_count} !== 4'h0) begin
      failures++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.corr_count, bus.uncorr_count);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.enc_in_ready, bus.dec_in_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reset_readies got=%b exp=11", {bus.enc_in_ready, bus.dec_in_ready});
    end
  endtask

  task automatic test_encode();
    logic [6:0]  data [4];
    logic [11:0] exp  [4];
    data = '{7'h55, 7'h00, 7'h01, 7'h40};
    exp  = '{12'hA5F, 12'h000, 12'h00F, 12'h906};
    idleInputs();
    bus.enc_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.enc_data = data[i];
      step();
      checks++;
      if (bus.enc_out_valid !== 1'b1 || bus.enc_code !== exp[i]) begin
        failures++;
        $display("FAIL encode_%h got v=%0b code=%h exp v=1 code=%h", data[i], bus.enc_out_valid, bus.enc_code, exp[i]);
      end
    end
    bus.enc_in_valid = 1'b0;
    step();
    checks++;
    if (bus.enc_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL encode_drain got v=%0b exp=0", bus.enc_out_valid);
    end
    // Stall: output held and input refused until enc_out_ready returns
    bus.enc_out_ready = 1'b0;
    bus.enc_in_valid  = 1'b1;
    bus.enc_data      = 7'h55;
    step();
    bus.enc_data = 7'h00;
    step();
    checks++;
    if (bus.enc_in_ready !== 1'b0 || bus.enc_code !== 12'hA5F || bus.enc_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL encode_stall got rdy=%0b v=%0b code=%h exp rdy=0 v=1 code=a5f", bus.enc_in_ready,
               bus.enc_out_valid, bus.enc_code);
    end
    bus.enc_out_ready = 1'b1;
    #1;
    checks++;
    if (bus.enc_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL encode_release got rdy=%0b exp=1", bus.enc_in_ready);
    end
    step();
    checks++;
    if (bus.enc_code !== 12'h000) begin
      failures++;
      $display("FAIL encode_after_stall got=%h exp=000", bus.enc_code);
    end
    bus.enc_in_valid = 1'b0;
    step();
  endtask

  task automatic test_decode();
    logic [11:0] code [6];
    logic [6:0]  eData [6];
    logic        eCorr [6];
    logic        eUnc  [6];
    logic [3:0]  eSyn  [6];
    code  = '{12'hA5F, 12'hA1F, 12'hA5E, 12'hA77, 12'hB4E, 12'h25F};
    eData = '{7'h55,   7'h55,   7'h55,   7'h56,   7'h55,   7'h55};
    eCorr = '{1'b0,    1'b1,    1'b1,    1'b0,    1'b0,    1'b1};
    eUnc  = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b1,    1'b0};
    eSyn  = '{4'd0,    4'd6,    4'd0,    4'd6,    4'd12,   4'd11};
    idleInputs();
    for (int i = 0; i < 6; i++) begin
      bus.dec_in_valid = 1'b1;
      bus.dec_code     = code[i];
      step();
      bus.dec_in_valid = 1'b0;
      checks++;
      if (bus.dec_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL decode_latency_%h got v=%0b exp=0 after one cycle", code[i], bus.dec_out_valid);
      end
      step();
      checks++;
      if (bus.dec_out_valid !== 1'b1 || bus.dec_data !== eData[i] || bus.dec_corrected !== eCorr[i] ||
          bus.dec_uncorrectable !== eUnc[i] || bus.dec_syndrome !== eSyn[i]) begin
        failures++;
        $display("FAIL decode_%h got v=%0b d=%h c=%0b u=%0b s=%0d exp v=1 d=%h c=%0b u=%0b s=%0d", code[i],
                 bus.dec_out_valid, bus.dec_data, bus.dec_corrected, bus.dec_uncorrectable, bus.dec_syndrome,
                 eData[i], eCorr[i], eUnc[i], eSyn[i]);
      end
      if (eCorr[i] && expCorr < 3) expCorr++;
      if (eUnc[i] && expUncorr < 3) expUncorr++;
      step();
      checks++;
      if (bus.corr_count !== expCorr[1:0] || bus.uncorr_count !== expUncorr[1:0]) begin
        failures++;
        $display("FAIL decode_counts_%h got=%0d/%0d exp=%0d/%0d", code[i], bus.corr_count, bus.uncorr_count,
                 expCorr, expUncorr);
      end
    end
  endtask

  task automatic test_saturation();
    idleInputs();
    for (int i = 0; i < 2; i++) begin
      bus.dec_in_valid = 1'b1;
      bus.dec_code     = 12'hA1F;
      step();
      bus.dec_in_valid = 1'b0;
      step();
      step();
      checks++;
      if (bus.corr_count !== 2'd3) begin
        failures++;
        $display("FAIL saturate_%0d got=%0d exp=3", i, bus.corr_count);
      end
    end
    bus.dec_in_valid = 1'b1;
    bus.dec_code     = 12'hA1F;
    step();
    bus.dec_in_valid = 1'b0;
    step();
    bus.cnt_clear = 1'b1;
    step();
    bus.cnt_clear = 1'b0;
    expCorr   = 0;
    expUncorr = 0;
    checks++;
    if (bus.corr_count !== 2'd0 || bus.uncorr_count !== 2'd0) begin
      failures++;
      $display("FAIL clear_with_event got=%0d/%0d exp=0/0", bus.corr_count, bus.uncorr_count);
    end
  endtask

  task automatic test_stall();
    idleInputs();
    bus.dec_out_ready = 1'b0;
    bus.dec_in_valid  = 1'b1;
    bus.dec_code      = 12'hA5F;
    step();
    checks++;
    if (bus.dec_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_one_word got rdy=%0b exp=1", bus.dec_in_ready);
    end
    bus.dec_code = 12'hA1F;
    step();
    checks++;
    if (bus.dec_in_ready !== 1'b0 || bus.dec_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_full got rdy=%0b v=%0b exp rdy=0 v=1", bus.dec_in_ready, bus.dec_out_valid);
    end
    bus.dec_code = 12'hA5E;
    step();
    step();
    checks++;
    if (bus.dec_data !== 7'h55 || bus.dec_corrected !== 1'b0 || bus.dec_syndrome !== 4'd0 ||
        bus.dec_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold got d=%h c=%0b s=%0d rdy=%0b exp d=55 c=0 s=0 rdy=0", bus.dec_data,
               bus.dec_corrected, bus.dec_syndrome, bus.dec_in_ready);
    end
    bus.dec_out_ready = 1'b1;
    #1;
    checks++;
    if (bus.dec_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_comb got rdy=%0b exp=1", bus.dec_in_ready);
    end
    step();
    bus.dec_in_valid = 1'b0;
    checks++;
    if (bus.dec_out_valid !== 1'b1 || bus.dec_corrected !== 1'b1 || bus.dec_syndrome !== 4'd6) begin
      failures++;
      $display("FAIL stall_second got v=%0b c=%0b s=%0d exp v=1 c=1 s=6", bus.dec_out_valid, bus.dec_corrected,
               bus.dec_syndrome);
    end
    step();
    checks++;
    if (bus.dec_out_valid !== 1'b1 || bus.dec_corrected !== 1'b1 || bus.dec_syndrome !== 4'd0 ||
        bus.dec_data !== 7'h55) begin
      failures++;
      $display("FAIL stall_third got v=%0b c=%0b s=%0d d=%h exp v=1 c=1 s=0 d=55", bus.dec_out_valid,
               bus.dec_corrected, bus.dec_syndrome, bus.dec_data);
    end
    step();
    expCorr = 2;
    checks++;
    if (bus.dec_out_valid !== 1'b0 || bus.corr_count !== expCorr[1:0]) begin
      failures++;
      $display("FAIL stall_drain got v=%0b corr=%0d exp v=0 corr=%0d", bus.dec_out_valid, bus.corr_count, expCorr);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  src [20];
    logic [11:0] codeQ [$];
    int sIdx;
    int oIdx;
    logic encIn, encOut, decIn, decOut;
    for (int i = 0; i < 20; i++) src[i] = 7'((i * 37 + 5) % 128);
    sIdx = 0;
    oIdx = 0;
    idleInputs();
    for (int cyc = 0; cyc < 600 && oIdx < 20; cyc++) begin
      bus.enc_out_ready = 1'($urandom_range(0, 1));
      bus.dec_out_ready = 1'($urandom_range(0, 1));
      bus.enc_in_valid  = (sIdx < 20);
      bus.enc_data      = (sIdx < 20) ? src[sIdx] : 7'h0;
      bus.dec_in_valid  = (codeQ.size() > 0);
      bus.dec_code      = (codeQ.size() > 0) ? codeQ[0] : 12'h0;
      #1;
      encIn  = bus.enc_in_valid && bus.enc_in_ready;
      encOut = bus.enc_out_valid && bus.enc_out_ready;
      decIn  = bus.dec_in_valid && bus.dec_in_ready;
      decOut = bus.dec_out_valid && bus.dec_out_ready;
      if (decOut) begin
        checks++;
        if (oIdx >= 20) begin
          failures++;
          $display("FAIL stream_extra got word %h beyond 20 exp none", bus.dec_data);
        end else if ({bus.dec_corrected, bus.dec_uncorrectable, bus.dec_syndrome, bus.dec_data} !==
                     {2'b00, 4'd0, src[oIdx]}) begin
          failures++;
          $display("FAIL stream_word_%0d got d=%h c=%0b u=%0b s=%0d exp d=%h clean", oIdx, bus.dec_data,
                   bus.dec_corrected, bus.dec_uncorrectable, bus.dec_syndrome, src[oIdx]);
        end
        oIdx++;
      end
      if (decIn) void'(codeQ.pop_front());
      if (encOut) codeQ.push_back(bus.enc_code);
      if (encIn) sIdx++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (oIdx != 20) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=20 within cycle budget", oIdx);
    end
    idleInputs();
    step();
    step();
    step();
    checks++;
    if (bus.dec_out_valid !== 1'b0 || bus.enc_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_no_dup got dv=%0b ev=%0b exp 0/0", bus.dec_out_valid, bus.enc_out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    idleInputs();
    bus.enc_out_ready = 1'b0;
    bus.dec_out_ready = 1'b0;
    bus.enc_in_valid  = 1'b1;
    bus.enc_data      = 7'h2A;
    bus.dec_in_valid  = 1'b1;
    bus.dec_code      = 12'hA1F;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({bus.enc_out_valid, bus.enc_code, bus.dec_out_valid, bus.dec_data, bus.dec_corrected,
         bus.dec_uncorrectable, bus.dec_syndrome, bus.corr_count, bus.uncorr_count} !== 31'h0) begin
      failures++;
      $display("FAIL midstream_reset got ev=%0b ec=%h dv=%0b d=%h c=%0b u=%0b s=%0d cc=%0d uc=%0d exp all 0",
               bus.enc_out_valid, bus.enc_code, bus.dec_out_valid, bus.dec_data, bus.dec_corrected,
               bus.dec_uncorrectable, bus.dec_syndrome, bus.corr_count, bus.uncorr_count);
    end
    idleInputs();
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.enc_in_ready, bus.dec_in_ready, bus.enc_out_valid, bus.dec_out_valid} !== 4'b1100) begin
      failures++;
      $display("FAIL midstream_release got=%b exp=1100", {bus.enc_in_ready, bus.dec_in_ready,
               bus.enc_out_valid, bus.dec_out_valid});
    end
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_encode();
    test_decode();
    test_saturation();
    test_stall();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
